// File: rtl/nock_execute_unit.sv
// Nock execution unit: reduces the execute cell handed over by the MTU (opcode 1 only)
// and writes the result back in place through the shared memory port.
module nock_execute_unit #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              execute_start,
  input  logic [ADDR_W-1:0] execute_address,
  input  logic [4:0]        execute_tag,
  input  logic [DATA_W-1:0] execute_data,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] read_data,
  input  logic [ADDR_W-1:0] free_addr,
  output logic              mem_execute,
  output logic [1:0]        mem_func,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic              finished,
  output logic [7:0]        error,
  output logic [3:0]        execute_return_sys_func,
  output logic [3:0]        execute_return_state
);

  typedef enum logic [3:0] {
    IDLE, CHECK, WAIT_F, DECODE, WAIT_B, WRITE, WAIT_W, DONE, HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   a_q, a_d, address_d;
  logic [DATA_W-1:0]   w_q, w_d, f_q, f_d, res_q, res_d, write_data_d;
  logic                run_err_q, run_err_d, mem_execute_d, finished_d;
  logic [1:0]          mem_func_d;
  logic [7:0]          error_d;
  logic [3:0]          sys_d, ret_state_d;
  logic                mem_done;

  // mem_ready is still high during the strobe cycle itself; ignore it there.
  assign mem_done = mem_ready && !mem_execute;

  // Tag duplicates W[63:59] and free_addr is reserved; only some W/F bits are decoded.
  logic unused_bits;
  assign unused_bits = ^{free_addr, execute_tag, w_q, f_q};

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    w_d           = w_q;
    f_d           = f_q;
    res_d         = res_q;
    run_err_d     = run_err_q;
    mem_execute_d = 1'b0;
    mem_func_d    = mem_func;
    address_d     = address;
    write_data_d  = write_data;
    finished_d    = 1'b0;
    error_d       = error;
    sys_d         = execute_return_sys_func;
    ret_state_d   = execute_return_state;
    case (state_q)
      IDLE: if (execute_start) begin
        a_d       = execute_address;
        w_d       = execute_data;
        run_err_d = 1'b0;
        state_d   = CHECK;
      end
      CHECK: begin
        if (!w_q[63]) begin
          error_d = 8'h04; run_err_d = 1'b1; state_d = DONE;
        end else if (!w_q[61]) begin
          error_d = 8'h01; run_err_d = 1'b1; state_d = DONE;
        end else if (mem_ready) begin
          mem_execute_d = 1'b1;
          mem_func_d    = 2'b00;
          address_d     = w_q[ADDR_W-1:0];
          state_d       = WAIT_F;
        end
      end
      WAIT_F: if (mem_done) begin
        f_d     = read_data;
        state_d = DECODE;
      end
      DECODE: begin
        if (f_q[62]) begin
          error_d = 8'h03; run_err_d = 1'b1; state_d = DONE;
        end else if (f_q[55:28] != 28'd1) begin
          error_d = 8'h02; run_err_d = 1'b1; state_d = DONE;
        end else if (f_q[61]) begin
          if (mem_ready) begin
            mem_execute_d = 1'b1;
            mem_func_d    = 2'b00;
            address_d     = f_q[ADDR_W-1:0];
            state_d       = WAIT_B;
          end
        end else begin
          res_d   = {8'h10, 28'h0, f_q[27:0]};
          state_d = WRITE;
        end
      end
      WAIT_B: if (mem_done) begin
        res_d   = {1'b0, read_data[DATA_W-2:0]};
        state_d = WRITE;
      end
      WRITE: if (mem_ready) begin
        mem_execute_d = 1'b1;
        mem_func_d    = 2'b01;
        address_d     = a_q;
        write_data_d  = res_q;
        state_d       = WAIT_W;
      end
      WAIT_W: if (mem_done) state_d = DONE;
      DONE: begin
        finished_d  = 1'b1;
        sys_d       = run_err_q ? 4'hF : 4'h0;
        ret_state_d = run_err_q ? 4'hF : 4'h1;
        state_d     = HOLD;
      end
      // Wait for the MTU to drop start so the same cell is not re-executed.
      HOLD: if (!execute_start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q                 <= IDLE;
      a_q                     <= '0;
      w_q                     <= '0;
      f_q                     <= '0;
      res_q                   <= '0;
      run_err_q               <= 1'b0;
      mem_execute             <= 1'b0;
      mem_func                <= 2'b00;
      address                 <= '0;
      write_data              <= '0;
      finished                <= 1'b0;
      error                   <= 8'h00;
      execute_return_sys_func <= 4'h0;
      execute_return_state    <= 4'h0;
    end else begin
      state_q                 <= state_d;
      a_q                     <= a_d;
      w_q                     <= w_d;
      f_q                     <= f_d;
      res_q                   <= res_d;
      run_err_q               <= run_err_d;
      mem_execute             <= mem_execute_d;
      mem_func                <= mem_func_d;
      address                 <= address_d;
      write_data              <= write_data_d;
      finished                <= finished_d;
      error                   <= error_d;
      execute_return_sys_func <= sys_d;
      execute_return_state    <= ret_state_d;
    end
  end

endmodule

// File: tb/tb_nock_execute_unit.sv
// Scoreboard bench for nock_execute_unit: expected memory requests and completions are
// queued by the stimulus; a monitor pops and compares them as the DUT presents them.
module tb_nock_execute_unit;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              execute_start = 1'b0;
  logic [ADDR_W-1:0] execute_address = '0;
  logic [4:0]        execute_tag = '0;
  logic [DATA_W-1:0] execute_data = '0;
  logic              mem_ready;
  logic [DATA_W-1:0] read_data;
  logic [ADDR_W-1:0] free_addr = 10'd100;
  logic              mem_execute;
  logic [1:0]        mem_func;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic              finished;
  logic [7:0]        error;
  logic [3:0]        execute_return_sys_func;
  logic [3:0]        execute_return_state;

  nock_execute_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .execute_start(execute_start),
    .execute_address(execute_address), .execute_tag(execute_tag),
    .execute_data(execute_data), .mem_ready(mem_ready), .read_data(read_data),
    .free_addr(free_addr), .mem_execute(mem_execute), .mem_func(mem_func),
    .address(address), .write_data(write_data), .finished(finished), .error(error),
    .execute_return_sys_func(execute_return_sys_func),
    .execute_return_state(execute_return_state)
  );

  always #5 clk = ~clk;

  // Memory model: drops ready the cycle after a strobe, completes one cycle later.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              busy;
  logic [1:0]        m_func;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wd;
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [DATA_W-1:0] pl_data = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_ready <= 1'b1; busy <= 1'b0; read_data <= '0;
      m_func <= '0; m_addr <= '0; m_wd <= '0;
    end else begin
      if (pl_en) mem[pl_addr] <= pl_data;
      if (busy) begin
        mem_ready <= 1'b1; busy <= 1'b0;
        if (m_func == 2'b00) read_data <= mem[m_addr];
        else mem[m_addr] <= m_wd;
      end else if (mem_execute && mem_ready) begin
        mem_ready <= 1'b0; busy <= 1'b1;
        m_func <= mem_func; m_addr <= address; m_wd <= write_data;
      end
    end
  end

  typedef struct {
    logic              is_mem;
    logic [1:0]        func;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [7:0]        err;
    logic [3:0]        sys;
    logic [3:0]        st;
  } exp_t;

  exp_t q[$];
  int   checks = 0, passes = 0;
  int   fin_cnt = 0;

  // All counter updates go through the monitor process or the stimulus process via these
  // events-free helpers; the monitor is an initial block so both are plain processes.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mem_execute) begin
          checks++;
          if (q.size() == 0 || !q[0].is_mem) begin
            $display("FAIL mem_req unexpected: func=%0d addr=%0d data=%h", mem_func, address, write_data);
            if (q.size() != 0) void'(q.pop_front());
          end else begin
            e = q.pop_front();
            if (mem_func == e.func && address == e.addr && (e.func == 2'b00 || write_data == e.data))
              passes++;
            else
              $display("FAIL mem_req: got func=%0d addr=%0d data=%h, want func=%0d addr=%0d data=%h",
                       mem_func, address, write_data, e.func, e.addr, e.data);
          end
        end
        if (finished) begin
          fin_cnt++;
          checks++;
          if (q.size() == 0 || q[0].is_mem) begin
            $display("FAIL finish unexpected: err=%h sys=%h st=%h", error,
                     execute_return_sys_func, execute_return_state);
            if (q.size() != 0) void'(q.pop_front());
          end else begin
            e = q.pop_front();
            if (error == e.err && execute_return_sys_func == e.sys && execute_return_state == e.st)
              passes++;
            else
              $display("FAIL finish: got err=%h sys=%h st=%h, want err=%h sys=%h st=%h",
                       error, execute_return_sys_func, execute_return_state, e.err, e.sys, e.st);
          end
        end
      end
    end
  end

  function automatic exp_t mk_mem(input logic [1:0] f, input logic [ADDR_W-1:0] a,
                                  input logic [DATA_W-1:0] d);
    exp_t e;
    e.is_mem = 1'b1; e.func = f; e.addr = a; e.data = d; e.err = '0; e.sys = '0; e.st = '0;
    return e;
  endfunction

  function automatic exp_t mk_fin(input logic [7:0] er, input logic [3:0] s, input logic [3:0] t);
    exp_t e;
    e.is_mem = 1'b0; e.func = '0; e.addr = '0; e.data = '0; e.err = er; e.sys = s; e.st = t;
    return e;
  endfunction

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic run(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] w, input string name);
    int f0;
    f0 = fin_cnt;
    @(negedge clk);
    execute_address = a; execute_data = w; execute_tag = w[63:59]; execute_start = 1'b1;
    for (int i = 0; i < 200 && fin_cnt == f0; i++) @(posedge clk);
    @(negedge clk);
    execute_start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (fin_cnt != f0 && q.size() == 0) passes++;
    else $display("FAIL %s drain: finishes=%0d outstanding=%0d, want 1 and 0", name, fin_cnt - f0, q.size());
  endtask

  task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  localparam logic [DATA_W-1:0] W_OK   = 64'hA000_0000_0000_0002;
  localparam logic [DATA_W-1:0] B_CELL = 64'h0000_0030_0000_0004;

  initial begin : stim
    logic hit;
    repeat (2) @(posedge clk);
    #1;
    chk("rst mem_execute", {63'd0, mem_execute}, 64'd0);
    chk("rst mem_func", {62'd0, mem_func}, 64'd0);
    chk("rst address", {54'd0, address}, 64'd0);
    chk("rst write_data", write_data, 64'd0);
    chk("rst finished", {63'd0, finished}, 64'd0);
    chk("rst error", {56'd0, error}, 64'd0);
    chk("rst return", {56'd0, execute_return_sys_func, execute_return_state}, 64'd0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);

    // constant opcode, atom b
    preload(10'd2, 64'h0000_0000_1000_002A);
    q.push_back(mk_mem(2'b00, 10'd2, '0));
    q.push_back(mk_mem(2'b01, 10'd1, 64'h1000_0000_0000_002A));
    q.push_back(mk_fin(8'h00, 4'h0, 4'h1));
    run(10'd1, W_OK, "atom");
    chk("atom mem1", mem[1], 64'h1000_0000_0000_002A);

    // constant opcode, cell b
    preload(10'd2, 64'h2000_0000_1000_0005);
    preload(10'd5, B_CELL);
    q.push_back(mk_mem(2'b00, 10'd2, '0));
    q.push_back(mk_mem(2'b00, 10'd5, '0));
    q.push_back(mk_mem(2'b01, 10'd1, B_CELL));
    q.push_back(mk_fin(8'h00, 4'h0, 4'h1));
    run(10'd1, W_OK, "cell");
    chk("cell mem1", mem[1], B_CELL);

    // unsupported opcode 7: no write
    preload(10'd2, 64'h0000_0000_7000_002A);
    q.push_back(mk_mem(2'b00, 10'd2, '0));
    q.push_back(mk_fin(8'h02, 4'hF, 4'hF));
    run(10'd1, W_OK, "op7");
    chk("op7 mem1 untouched", mem[1], B_CELL);

    // formula is not a cell: no memory traffic at all
    q.push_back(mk_fin(8'h01, 4'hF, 4'hF));
    run(10'd1, 64'h8000_0000_0000_0002, "notcell");

    // exec flag clear
    q.push_back(mk_fin(8'h04, 4'hF, 4'hF));
    run(10'd1, 64'h2000_0000_0000_0002, "noexec");

    // success after an error keeps the latched error code
    preload(10'd2, 64'h0000_0000_1000_0063);
    q.push_back(mk_mem(2'b00, 10'd2, '0));
    q.push_back(mk_mem(2'b01, 10'd1, 64'h1000_0000_0000_0063));
    q.push_back(mk_fin(8'h04, 4'h0, 4'h1));
    run(10'd1, W_OK, "sticky");
    chk("sticky mem1", mem[1], 64'h1000_0000_0000_0063);

    // reset while waiting for b
    preload(10'd2, 64'h2000_0000_1000_0005);
    q.push_back(mk_mem(2'b00, 10'd2, '0));
    @(negedge clk);
    execute_address = 10'd1; execute_data = W_OK; execute_tag = W_OK[63:59]; execute_start = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk); #1;
      if (mem_execute && address == 10'd5) hit = 1'b1;
    end
    chk("midB reached", {63'd0, hit}, 64'd1);
    rst = 1'b0;
    #1;
    chk("midB mem_execute", {63'd0, mem_execute}, 64'd0);
    chk("midB address", {54'd0, address}, 64'd0);
    chk("midB error", {56'd0, error}, 64'd0);
    chk("midB return", {56'd0, execute_return_sys_func, execute_return_state}, 64'd0);
    @(negedge clk);
    execute_start = 1'b0;
    @(negedge clk) rst = 1'b1;
    hit = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (mem_execute || finished) hit = 1'b1;
    end
    chk("post-rst idle", {63'd0, hit}, 64'd0);
    chk("post-rst queue", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/nock_execute_unit.md
Name: nock_execute_unit

Overview:
- Nock Execution Module (NEM). It sits beside the memory traversal unit (MTU) and shares the single memory_unit port through a 2:1 memory mux.
- While the MTU holds execute_start high, the NEM owns memory. It reduces the execute cell the MTU handed over, writes the result back in place, and pulses finished.
- Supported reduction: Nock opcode 1 (constant, *[a 1 b] -> b). Any other opcode ends in a latched error.

Parameters:
ADDR_W, 10, memory address width (`memory_addr_width).
DATA_W, 64, memory word width (`memory_data_width).

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  asynchronous, active-low reset
execute_start  in  1  level from MTU; high = NEM owns memory
execute_address  in  ADDR_W  address of the execute cell A
execute_tag  in  5  word[63:59] of A
execute_data  in  DATA_W  full word of A
mem_ready  in  1  memory idle / result valid
read_data  in  DATA_W  memory read result
free_addr  in  ADDR_W  next free cell; unused by this block, reserved
mem_execute  out  1  memory request strobe
mem_func  out  2  2'b00 read, 2'b01 write
address  out  ADDR_W  memory address
write_data  out  DATA_W  memory write word
finished  out  1  one-cycle completion pulse
error  out  8  latched error code, 0 = none
execute_return_sys_func  out  4  MTU resume function
execute_return_state  out  4  MTU resume state

Behaviour:
- Word layout:
  - [63] exec flag; [62] head_is_ptr; [61] tail_is_ptr; [60] is_atom_word; [59:56] reserved 0.
  - [55:28] head field; [27:0] tail field (pointer or direct atom).
  - execute_tag[4:3] therefore gives {exec, head_is_ptr}, and execute_tag[2] gives tail_is_ptr.
- Reset (rst=0, async): state IDLE. All outputs 0 (mem_execute, mem_func, address, write_data, finished, error, return outputs). Reset mid-operation aborts immediately; no memory request is left asserted.
- Memory handshake:
  - Issue a request only when mem_ready=1, with mem_execute=1 for exactly one cycle.
  - Hold mem_func, address and write_data stable until the transaction completes.
  - Memory drops mem_ready the cycle after the strobe. The NEM waits for mem_ready=1 again; read_data is valid in that cycle.
- FSM:
  - IDLE: on execute_start=1, latch execute_address to A and execute_data to W. Go to CHECK.
  - CHECK:
    - W[63]=0 -> error 8'h04.
    - W[61]=0 (formula not a cell) -> error 8'h01.
    - Otherwise request read of W[27:0] (formula F) -> WAIT_F.
  - WAIT_F: on ready, latch F -> DECODE.
  - DECODE:
    - F[62]=1 (opcode is a cell) -> error 8'h03.
    - F[55:28] != 1 -> error 8'h02.
    - Else if F[61]=1 (b is a cell): request read of F[27:0] -> WAIT_B.
    - Else: build atom result {8'h10, 28'h0, F[27:0]} -> WRITE.
  - WAIT_B: on ready, take result = read_data with bit 63 cleared -> WRITE.
  - WRITE: request write of result to A (func 2'b01) -> WAIT_W.
  - WAIT_W: on ready -> DONE.
  - DONE:
    - finished=1 for one cycle.
    - Success: sys_func=4'h0, state=4'h1 (MTU re-reads A).
    - Error path: sys_func=4'hF, state=4'hF (halt); error latched.
    - Go to HOLD.
  - HOLD: wait for execute_start=0, then IDLE. This prevents retrigger while the MTU takes the bus back.
- Errors:
  - Every error path skips the remaining memory operations and goes straight to DONE.
  - error holds its value until reset. A later success does not clear it.
- Return outputs hold their value until the next DONE or reset.
- Latency, zero-wait memory (success, atom b): execute_start to finished ≈ 7 cycles.

Test Plan:
- Reset held low 2 cycles, then released -> all outputs 0, FSM idle, no mem_execute.
- A=1, W={8'hA0,28'h0,28'h2}; mem[2]={8'h00,28'd1,28'd42}; start -> read 2, write mem[1]=64'h1000_0000_0000_002A, finished pulse, sys_func=0, state=1, error=0.
- Same but mem[2]={8'h20,28'd1,28'd5} and mem[5]=64'h0000_0030_0000_0004 -> reads 2 then 5, writes mem[1]=64'h0000_0030_0000_0004.
- mem[2] opcode 28'd7 -> no write, error=8'h02, finished pulse, sys_func=state=4'hF.
- W[61]=0 -> error=8'h01 with zero memory requests.
- Assert rst mid-WAIT_B -> outputs 0 at once. After release with execute_start low, the block stays idle.
